// File: rtl/ls_down_timer.sv
// Loadable down-counter/timer with ENP/ENT enables, one-cycle DONE on expiry,
// and optional auto-reload of the last loaded value for periodic operation.
module ls_down_timer #(
   parameter int WIDTH = 4
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic [WIDTH-1:0] D,
   input  logic             LOAD_n,
   input  logic             ENP,
   input  logic             ENT,
   input  logic             RELOAD,
   output logic [WIDTH-1:0] Q,
   output logic [1:0]       STATE,
   output logic             DONE,
   output logic             BO
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_EXPIRED = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] C_ZERO = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] r_reload;
   logic [WIDTH-1:0] w_reload_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic             w_count_en;

   assign w_count_en = ENP & ENT;

   // State, count, reload value and expiry pulse registers.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state  <= ST_IDLE;
         r_q      <= C_ZERO;
         r_reload <= C_ZERO;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_q      <= w_q_nxt;
         r_reload <= w_reload_nxt;
         r_done   <= w_done_nxt;
      end
   end

   // Next-state logic: load beats counting, so a load on the expiry edge suppresses DONE.
   always_comb begin
      w_state_nxt  = r_state;
      w_q_nxt      = r_q;
      w_reload_nxt = r_reload;
      w_done_nxt   = 1'b0;
      if (!LOAD_n) begin
         w_q_nxt      = D;
         w_reload_nxt = D;
         if (D != C_ZERO) begin
            w_state_nxt = ST_RUN;
         end else begin
            w_state_nxt = ST_IDLE;
         end
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_q_nxt = r_q;
            end
            ST_RUN: begin
               if (w_count_en) begin
                  if (r_q > C_ONE) begin
                     w_q_nxt = r_q - C_ONE;
                  end else if (r_q == C_ONE) begin
                     w_done_nxt = 1'b1;
                     if (RELOAD) begin
                        w_q_nxt = r_reload;
                     end else begin
                        w_q_nxt     = C_ZERO;
                        w_state_nxt = ST_EXPIRED;
                     end
                  end else begin
                     // RUN with a zero count cannot arise from a load; park safely.
                     w_q_nxt     = C_ZERO;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_q_nxt = r_q;
               end
            end
            ST_EXPIRED: begin
               w_q_nxt = C_ZERO;
            end
            default: begin
               w_q_nxt     = C_ZERO;
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   assign Q     = r_q;
   assign STATE = r_state;
   assign DONE  = r_done;
   assign BO    = ENT & (r_q == C_ZERO);

endmodule

// File: tb/tb_ls_down_timer.sv
// Bench for ls_down_timer: directed scenarios with literal expectations, then
// randomized stimulus checked every cycle against a behavioural timer model.
module tb_ls_down_timer;

   localparam int WIDTH = 4;
   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_EXP  = 2;

   logic             CLK;
   logic             CLR;
   logic [WIDTH-1:0] D;
   logic             LOAD_n;
   logic             ENP;
   logic             ENT;
   logic             RELOAD;
   logic [WIDTH-1:0] Q;
   logic [1:0]       STATE;
   logic             DONE;
   logic             BO;

   ls_down_timer #(.WIDTH(WIDTH)) dut (
      .CLK(CLK), .CLR(CLR), .D(D), .LOAD_n(LOAD_n), .ENP(ENP), .ENT(ENT),
      .RELOAD(RELOAD), .Q(Q), .STATE(STATE), .DONE(DONE), .BO(BO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // behavioural model
   int m_q   = 0;
   int m_r   = 0;
   int m_st  = S_IDLE;
   int m_done = 0;

   // hand-computed expectations, written only by the stimulus process
   bit exp_valid = 1'b0;
   int exp_q, exp_st, exp_done, exp_bo;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Model update and comparison after every clock edge and every reset assertion.
   always @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         m_q = 0; m_r = 0; m_st = S_IDLE; m_done = 0;
      end else begin
         m_done = 0;
         if (!LOAD_n) begin
            m_q  = int'(D);
            m_r  = int'(D);
            m_st = (m_q != 0) ? S_RUN : S_IDLE;
         end else if (m_st == S_RUN && ENP && ENT) begin
            if (m_q == 1) begin
               m_done = 1;
               if (RELOAD) m_q = m_r;
               else begin
                  m_q  = 0;
                  m_st = S_EXP;
               end
            end else if (m_q > 1) begin
               m_q = m_q - 1;
            end
         end
      end
      #1;
      chk("model_q", int'(Q), m_q);
      chk("model_state", int'(STATE), m_st);
      chk("model_done", int'(DONE), m_done);
      chk("model_bo", int'(BO), (ENT && m_q == 0) ? 1 : 0);
      if (exp_valid) begin
         chk("lit_q", int'(Q), exp_q);
         chk("lit_state", int'(STATE), exp_st);
         chk("lit_done", int'(DONE), exp_done);
         chk("lit_bo", int'(BO), exp_bo);
      end
   end

   // One clock of stimulus with a literal expectation for the outputs after the edge.
   task automatic cyc(input bit ld_n, input int d, input bit enp, input bit ent,
                      input bit rel, input int eq, input int est, input int edn);
      @(negedge CLK);
      LOAD_n = ld_n; D = d[WIDTH-1:0]; ENP = enp; ENT = ent; RELOAD = rel;
      exp_q = eq; exp_st = est; exp_done = edn;
      exp_bo = (ent && eq == 0) ? 1 : 0;
      exp_valid = 1'b1;
      @(posedge CLK);
      #3;
      exp_valid = 1'b0;
   endtask

   // Assert CLR between edges and expect an immediate reset state.
   task automatic async_clr(input bit ent);
      @(negedge CLK);
      ENT = ent; ENP = 1'b1; LOAD_n = 1'b1;
      exp_q = 0; exp_st = S_IDLE; exp_done = 0; exp_bo = ent ? 1 : 0;
      #2;
      exp_valid = 1'b1;
      CLR = 1'b1;
      #2;
      exp_valid = 1'b0;
      @(negedge CLK);
      CLR = 1'b0;
   endtask

   initial begin
      CLR = 1'b1; D = '0; LOAD_n = 1'b1; ENP = 1'b0; ENT = 1'b0; RELOAD = 1'b0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      CLR = 1'b0;

      // reset pulse between edges, BO follows ENT
      async_clr(1'b1);

      // one-shot from 3
      cyc(0, 3, 1, 1, 0, 3, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 2, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 1, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 0, S_EXP, 1);
      for (int i = 0; i < 5; i++) cyc(1, 15, 1, 1, 0, 0, S_EXP, 0);

      // auto-reload with period 2
      cyc(0, 2, 1, 1, 1, 2, S_RUN, 0);
      cyc(1, 0, 1, 1, 1, 1, S_RUN, 0);
      cyc(1, 0, 1, 1, 1, 2, S_RUN, 1);
      cyc(1, 0, 1, 1, 1, 1, S_RUN, 0);
      cyc(1, 0, 1, 1, 1, 2, S_RUN, 1);
      cyc(1, 0, 1, 1, 1, 1, S_RUN, 0);

      // reload value 1: DONE on every enabled cycle
      cyc(0, 1, 1, 1, 1, 1, S_RUN, 0);
      cyc(1, 0, 1, 1, 1, 1, S_RUN, 1);
      cyc(1, 0, 1, 1, 1, 1, S_RUN, 1);
      cyc(1, 0, 0, 1, 1, 1, S_RUN, 0);

      // enable gating from 5
      cyc(0, 5, 1, 1, 0, 5, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 4, S_RUN, 0);
      cyc(1, 0, 0, 1, 0, 4, S_RUN, 0);
      cyc(1, 0, 0, 1, 0, 4, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 3, S_RUN, 0);
      cyc(1, 0, 1, 0, 0, 3, S_RUN, 0);
      cyc(1, 0, 1, 0, 0, 3, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 2, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 1, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 0, S_EXP, 1);
      cyc(1, 0, 1, 0, 0, 0, S_EXP, 0);

      // load collides with expiry, then load of zero
      cyc(0, 2, 1, 1, 0, 2, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 1, S_RUN, 0);
      cyc(0, 9, 1, 1, 0, 9, S_RUN, 0);
      cyc(0, 0, 1, 1, 0, 0, S_IDLE, 0);
      cyc(1, 7, 1, 1, 0, 0, S_IDLE, 0);

      // reset mid-run, enables alone do not restart
      cyc(0, 7, 1, 1, 0, 7, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 6, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 5, S_RUN, 0);
      cyc(1, 0, 1, 1, 0, 4, S_RUN, 0);
      async_clr(1'b0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 0, 0, S_IDLE, 0);

      // randomized phase, model-checked every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         CLR    = ($urandom_range(0, 299) == 0);
         LOAD_n = ($urandom_range(0, 9) != 0);
         D      = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
         ENP    = ($urandom_range(0, 3) != 0);
         ENT    = ($urandom_range(0, 3) != 0);
         RELOAD = $urandom_range(0, 1) == 1;
      end
      @(negedge CLK);
      CLR = 1'b0;
      repeat (2) @(negedge CLK);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
